sram_mem_controller: RTL and testbench
======================================

SRAM_MEM_CONTROLLER -- requirements
Module: sram_mem_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, clock cycles each 16-bit SRAM half-access lasts; legal range 2..15.
REQ-002 Parameter DATA_BASE, default 32'd1024, byte address mapped to SRAM word 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 rd_en  in  1  memory-stage load request (MEM_R_en from the EXE/MEM register).
REQ-006 wr_en  in  1  memory-stage store request.
REQ-007 address  in  32  byte address (ALU result).
REQ-008 write_data  in  32  store data.
REQ-009 read_data  out  32  load result, feeds Mem_read_value_in of the MEM/WB register.
REQ-010 ready  out  1  access complete; low freezes the pipeline.
REQ-011 SRAM_DQ  inout  16  external SRAM data bus.
REQ-012 SRAM_ADDR  out  18  external half-word address.
REQ-013 SRAM_WE_N  out  1  active-low write strobe.
REQ-014 SRAM_OE_N  out  1  active-low output enable.

Function
REQ-015 States: IDLE, LOW, HIGH, DONE; 4-bit wait counter cnt.
REQ-016 Word index idx = (address - DATA_BASE) >> 2, 17 bits, wraps modulo 2^17; LOW half address = {idx,1'b0}, HIGH = {idx,1'b1}.
REQ-017 IDLE: ready = ~(rd_en | wr_en) (combinational); request present -> latch op, idx, write_data; go to LOW with cnt=0.
REQ-018 rd_en and wr_en both high -> write performed; read_data unchanged.
REQ-019 Inputs changing while in LOW/HIGH/DONE are ignored; only latched values are used.
REQ-020 LOW/HIGH: cnt increments each cycle; at cnt = WAIT_CYCLES-1 advance (LOW->HIGH, HIGH->DONE) and clear cnt.
REQ-021 Read: SRAM_OE_N=0 throughout LOW/HIGH; SRAM_DQ hi-Z; on final LOW cycle capture SRAM_DQ into read_data[15:0]; final HIGH cycle into read_data[31:16].
REQ-022 Write: SRAM_DQ driven with write_data[15:0] in LOW, [31:16] in HIGH; SRAM_WE_N=0 all cycles of each phase except its final cycle (=1, hold); SRAM_OE_N=1.
REQ-023 SRAM_DQ hi-Z in IDLE, DONE and all read cycles; SRAM_WE_N=1, SRAM_OE_N=1 in IDLE and DONE.
REQ-024 DONE: ready=1 for exactly one cycle, then IDLE unconditionally (pipeline advances on that edge).
REQ-025 Latency: request first seen in cycle 0 -> ready low cycles 0..2*WAIT_CYCLES, high in cycle 2*WAIT_CYCLES+1.
REQ-026 Back-to-back requests: new request seen in IDLE the cycle after DONE; no cycle skipped or merged.
REQ-027 read_data holds last loaded value until next read completes its LOW capture.
REQ-028 SRAM_ADDR holds last value in IDLE/DONE.

Reset
REQ-029 rst low, any state: immediately state=IDLE, cnt=0, read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ hi-Z; ready follows REQ-017.
REQ-030 Reset mid-access abandons it; partial write not retried; first edge after release evaluates requests from IDLE.

Verification
REQ-031 W=2, rd_en=1, address=1024, SRAM model word0=0xBEEF_1234 -> SRAM_ADDR 0 then 1, ready low cycles 0-4, high cycle 5, read_data=0xBEEF1234.
REQ-032 wr_en=1, address=1032, write_data=0xCAFE_0001 -> SRAM_ADDR 4 with DQ=0x0001, then 5 with DQ=0xCAFE; WE_N low one cycle per phase; later read of 1032 returns 0xCAFE0001.
REQ-033 rd_en=wr_en=1 -> write executed, read_data unchanged, ready timing per REQ-025.
REQ-034 Load then store back-to-back held requests -> two ready pulses exactly 6 cycles apart, ready low between.
REQ-035 rst asserted in HIGH of a write -> immediate IDLE, WE_N=1, DQ hi-Z, read_data=0; SRAM high half not written.
REQ-036 No request -> ready=1 continuously, WE_N=OE_N=1, DQ hi-Z.

Source files
------------

// File: rtl/sram_mem_controller_if.sv
// Pipeline-side bus of the SRAM memory controller.
// The memory stage (master) issues load/store requests and is stalled while
// ready is low. The controller (slave) returns the assembled 32-bit load data.
interface sram_mem_controller_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;

   modport master (
      output rd_en, wr_en, address, write_data,
      input  read_data, ready
   );

   modport slave (
      input  rd_en, wr_en, address, write_data,
      output read_data, ready
   );
endinterface

// File: rtl/sram_mem_controller.sv
// SRAM memory controller: turns one 32-bit load/store from the memory stage
// into two 16-bit SRAM half-accesses (low half-word, then high half-word),
// each lasting WAIT_CYCLES clocks, and holds the pipeline until both finish.
module sram_mem_controller #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] DATA_BASE   = 32'd1024
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_mem_controller_if.slave bus,
   inout  wire  [15:0]          SRAM_DQ,
   output logic [17:0]          SRAM_ADDR,
   output logic                 SRAM_WE_N,
   output logic                 SRAM_OE_N
);

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t      state;
   state_t      next_state;
   logic [3:0]  cnt;
   logic        op_write;
   logic [16:0] idx;
   logic [31:0] wdata_q;

   logic        request;
   logic [16:0] req_idx;
   logic        last_cycle;
   logic        dq_drive;
   logic [15:0] dq_out;
   logic        ready_c;

   // A store wins when both requests are raised together, so any request
   // simply latches wr_en as the operation type.
   assign request    = bus.rd_en | bus.wr_en;
   // Word index relative to the data segment; the 17-bit truncation makes
   // addresses below DATA_BASE wrap to the top of the SRAM.
   assign req_idx    = 17'((bus.address - DATA_BASE) >> 2);
   assign last_cycle = (cnt == LAST_CNT);

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state logic: each half lasts WAIT_CYCLES clocks, DONE lasts one.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (request)    next_state = LOW;
         LOW:     if (last_cycle) next_state = HIGH;
         HIGH:    if (last_cycle) next_state = DONE;
         DONE:                    next_state = IDLE;
         default:                 next_state = IDLE;
      endcase
   end

   // Wait counter runs only inside a half-access and restarts at each phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= 4'd0;
      end else if ((state == LOW) || (state == HIGH)) begin
         cnt <= last_cycle ? 4'd0 : cnt + 4'd1;
      end else begin
         cnt <= 4'd0;
      end
   end

   // Capture the request once in IDLE so later input changes are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_write <= 1'b0;
         idx      <= 17'd0;
         wdata_q  <= 32'd0;
      end else if ((state == IDLE) && request) begin
         op_write <= bus.wr_en;
         idx      <= req_idx;
         wdata_q  <= bus.write_data;
      end
   end

   // SRAM half-word address is registered so it holds in IDLE and DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         SRAM_ADDR <= 18'd0;
      end else if ((state == IDLE) && request) begin
         SRAM_ADDR <= {req_idx, 1'b0};
      end else if ((state == LOW) && last_cycle) begin
         SRAM_ADDR <= {idx, 1'b1};
      end
   end

   // Load data is sampled on the last cycle of each half, when the SRAM
   // output has had the full wait time to settle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.read_data <= 32'd0;
      end else if (!op_write && last_cycle) begin
         if (state == LOW)  bus.read_data[15:0]  <= SRAM_DQ;
         if (state == HIGH) bus.read_data[31:16] <= SRAM_DQ;
      end
   end

   // Strobes and data drive: the write strobe is released on the final cycle
   // of each phase so data and address are held stable around its rising edge.
   always_comb begin
      ready_c   = 1'b0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      dq_drive  = 1'b0;
      dq_out    = wdata_q[15:0];
      case (state)
         IDLE: begin
            ready_c = ~request;
         end
         LOW: begin
            if (op_write) begin
               dq_drive  = 1'b1;
               dq_out    = wdata_q[15:0];
               SRAM_WE_N = last_cycle;
            end else begin
               SRAM_OE_N = 1'b0;
            end
         end
         HIGH: begin
            if (op_write) begin
               dq_drive  = 1'b1;
               dq_out    = wdata_q[31:16];
               SRAM_WE_N = last_cycle;
            end else begin
               SRAM_OE_N = 1'b0;
            end
         end
         DONE: begin
            ready_c = 1'b1;
         end
         default: begin
            ready_c = 1'b0;
         end
      endcase
   end

   assign bus.ready = ready_c;
   assign SRAM_DQ   = dq_drive ? dq_out : 16'bz;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Testbench for sram_mem_controller: a behavioural SRAM model, directed
// load/store vectors, and scoreboard monitors for completed accesses and
// for SRAM write strobes.
module tb_sram_mem_controller;

   localparam int W = 2;

   logic        clk;
   logic        rst;
   wire  [15:0] sram_dq;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic        sram_oe_n;

   sram_mem_controller_if bus ();

   sram_mem_controller #(
      .WAIT_CYCLES (W),
      .DATA_BASE   (32'd1024)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .SRAM_DQ   (sram_dq),
      .SRAM_ADDR (sram_addr),
      .SRAM_WE_N (sram_we_n),
      .SRAM_OE_N (sram_oe_n)
   );

   typedef struct {
      logic [31:0] data;
      int          low_cycles;
      string       name;
   } rd_exp_t;

   typedef struct {
      logic [17:0] addr;
      logic [15:0] data;
   } wr_exp_t;

   bit [15:0] sram [0:262143];
   rd_exp_t   rd_q[$];
   wr_exp_t   wr_q[$];
   int        assertions;
   int        failures;
   int        low_count;

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM read path: drives the bus only while output-enabled and not writing.
   assign sram_dq = (!sram_oe_n && sram_we_n) ? sram[sram_addr] : 16'hzzzz;

   // SRAM write path: a low write strobe stores the bus on the clock edge.
   always @(posedge clk) begin
      if (rst && !sram_we_n) sram[sram_addr] <= sram_dq;
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Completion monitor: every rising edge of ready after a stall is one
   // finished access; compare its load data and stall length.
   always @(negedge clk) begin
      if (!rst) begin
         low_count = 0;
      end else if (!bus.ready) begin
         low_count++;
      end else if (low_count > 0) begin
         if (rd_q.size() == 0) begin
            check_output("unexpected_completion", 32'd1, 32'd0);
         end else begin
            rd_exp_t e;
            e = rd_q.pop_front();
            check_output({e.name, "_read_data"}, bus.read_data, e.data);
            check_output({e.name, "_stall_cycles"}, 32'(low_count), 32'(e.low_cycles));
         end
         low_count = 0;
      end
   end

   // Write-strobe monitor: each low strobe cycle must match the next
   // expected half-word address and data.
   always @(negedge clk) begin
      if (rst && !sram_we_n) begin
         if (wr_q.size() == 0) begin
            check_output("unexpected_write_addr", 32'(sram_addr), 32'h0);
         end else begin
            wr_exp_t w;
            w = wr_q.pop_front();
            check_output("write_addr", 32'(sram_addr), 32'(w.addr));
            check_output("write_dq", 32'(sram_dq), 32'(w.data));
         end
      end
   end

   task automatic push_write(input logic [17:0] addr, input logic [15:0] data);
      wr_exp_t w;
      w.addr = addr;
      w.data = data;
      wr_q.push_back(w);
   endtask

   // Raise a request after the next clock edge and hold it until ready.
   task automatic apply_stimulus(input string name, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data);
      rd_exp_t e;
      bit      seen;
      @(posedge clk);
      #1;
      bus.rd_en      = rd;
      bus.wr_en      = wr;
      bus.address    = addr;
      bus.write_data = wdata;
      e.data       = exp_data;
      e.low_cycles = 2 * W + 1;
      e.name       = name;
      rd_q.push_back(e);
      seen = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         if (bus.ready) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check_output({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   task automatic check_idle(input string name);
      check_output({name, "_ready"}, 32'(bus.ready), 32'd1);
      check_output({name, "_we_n"}, 32'(sram_we_n), 32'd1);
      check_output({name, "_oe_n"}, 32'(sram_oe_n), 32'd1);
   endtask

   // Absolute bound on simulation time.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus.
   initial begin
      assertions     = 0;
      failures       = 0;
      low_count      = 0;
      rst            = 1'b0;
      bus.rd_en      = 1'b0;
      bus.wr_en      = 1'b0;
      bus.address    = 32'd0;
      bus.write_data = 32'd0;
      sram[0] = 16'h1234;
      sram[1] = 16'hBEEF;
      sram[2] = 16'h5678;
      sram[3] = 16'h9ABC;

      repeat (3) @(negedge clk);
      check_idle("reset");
      check_output("reset_read_data", bus.read_data, 32'h0);
      check_output("reset_sram_addr", 32'(sram_addr), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      check_idle("after_reset");

      $display("[TB] basic loads");
      apply_stimulus("load_1024", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hBEEF1234);
      apply_stimulus("load_1028", 1'b1, 1'b0, 32'd1028, 32'h0, 32'h9ABC5678);

      $display("[TB] store then load back");
      push_write(18'd4, 16'h0001);
      push_write(18'd5, 16'hCAFE);
      apply_stimulus("store_1032", 1'b0, 1'b1, 32'd1032, 32'hCAFE0001, 32'h9ABC5678);
      apply_stimulus("load_1032", 1'b1, 1'b0, 32'd1032, 32'h0, 32'hCAFE0001);

      $display("[TB] load then store back-to-back");
      apply_stimulus("load_1024b", 1'b1, 1'b0, 32'd1024, 32'h0, 32'hBEEF1234);
      push_write(18'd6, 16'hF00D);
      push_write(18'd7, 16'h0BAD);
      apply_stimulus("store_1036", 1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 32'hBEEF1234);

      $display("[TB] simultaneous read and write");
      push_write(18'd8, 16'h2222);
      push_write(18'd9, 16'h1111);
      apply_stimulus("rdwr_1040", 1'b1, 1'b1, 32'd1040, 32'h11112222, 32'hBEEF1234);

      $display("[TB] address below base wraps");
      push_write(18'h3FFFE, 16'h5A5A);
      push_write(18'h3FFFF, 16'hA5A5);
      apply_stimulus("store_1020", 1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 32'hBEEF1234);
      apply_stimulus("load_1020", 1'b1, 1'b0, 32'd1020, 32'h0, 32'hA5A55A5A);
      go_idle();

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle("idle");
      end
      check_output("idle_addr_hold", 32'(sram_addr), 32'h3FFFF);
      check_output("idle_data_hold", bus.read_data, 32'hA5A55A5A);
      check_output("mem_word_1036", {16'(sram[7]), 16'(sram[6])}, 32'h0BADF00D);

      $display("[TB] reset during high half of a store");
      push_write(18'd10, 16'h8888);
      @(posedge clk);
      #1;
      bus.wr_en      = 1'b1;
      bus.address    = 32'd1044;
      bus.write_data = 32'h77778888;
      repeat (3) @(posedge clk);
      #1;
      check_output("pre_reset_addr", 32'(sram_addr), 32'd11);
      check_output("pre_reset_we_n", 32'(sram_we_n), 32'd0);
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      #1;
      check_idle("mid_reset");
      check_output("mid_reset_read_data", bus.read_data, 32'h0);
      check_output("mid_reset_sram_addr", 32'(sram_addr), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("post_reset");
      check_output("partial_low_written", 32'(sram[10]), 32'h8888);
      check_output("partial_high_untouched", 32'(sram[11]), 32'h0);

      apply_stimulus("load_1036", 1'b1, 1'b0, 32'd1036, 32'h0, 32'h0BADF00D);
      go_idle();
      repeat (3) @(negedge clk);

      check_output("pending_completions", 32'(rd_q.size()), 32'd0);
      check_output("pending_writes", 32'(wr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
